// File: rtl/key_shift_loader.sv
// Serial key loader: assembles a LSB-first key in a shadow register and commits it atomically to key_out.
// Optional trailing even-parity beat is compiled in when KEY_PARITY_EN is defined.
module key_shift_loader #(
  parameter int KEY_W   = 8,
  parameter bit LOCK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             sdata,
  input  logic             svalid,
  output logic             sready,
  input  logic             lock_req,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             locked,
  output logic             err
);

  localparam int CNT_W = $clog2(KEY_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef KEY_PARITY_EN
    , CHECK
`endif
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [KEY_W-1:0]   shadow_reg;
  logic [KEY_W-1:0]   key_reg;
  logic [KEY_W-1:0]   commit_key;
  logic               key_valid_reg;
  logic               locked_reg;
  logic               in_load;
  logic               beat;
  logic               start_ok;
  logic               shift_beat;
  logic               last_beat;

  assign in_load    = (state_reg != IDLE);
  assign sready     = in_load;
  assign busy       = in_load;
  assign beat       = svalid & in_load;
  // Once locked the FSM can only sit in IDLE, so gating here covers every state.
  assign start_ok   = load_start & ~locked_reg;
  assign shift_beat = (state_reg == SHIFT) & beat & ~load_start;
  assign last_beat  = shift_beat & (count_reg == CNT_W'(KEY_W - 1));

  // Final key bit is taken straight from sdata so the commit needs no extra cycle.
  always_comb begin
    commit_key            = shadow_reg;
    commit_key[KEY_W-1]   = sdata;
  end

  genvar gi;
  generate
    for (gi = 0; gi < KEY_W; gi++) begin : g_shadow
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg[gi] <= 1'b0;
        end else if (start_ok) begin
          shadow_reg[gi] <= 1'b0;
        end else if (shift_beat && (count_reg == CNT_W'(gi))) begin
          shadow_reg[gi] <= sdata;
        end
      end
    end
  endgenerate

`ifdef KEY_PARITY_EN
  logic err_reg;
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      key_reg       <= '0;
      key_valid_reg <= 1'b0;
      locked_reg    <= 1'b0;
`ifdef KEY_PARITY_EN
      err_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            state_reg     <= SHIFT;
            count_reg     <= '0;
            key_valid_reg <= 1'b0;
`ifdef KEY_PARITY_EN
            err_reg       <= 1'b0;
`endif
          end else if (LOCK_EN && lock_req && key_valid_reg) begin
            locked_reg <= 1'b1;
          end
        end
        SHIFT: begin
          if (load_start) begin
            count_reg <= '0;
`ifdef KEY_PARITY_EN
            err_reg   <= 1'b0;
`endif
          end else if (beat) begin
            count_reg <= count_reg + 1'b1;
            if (last_beat) begin
`ifdef KEY_PARITY_EN
              state_reg <= CHECK;
`else
              state_reg     <= IDLE;
              key_reg       <= commit_key;
              key_valid_reg <= 1'b1;
`endif
            end
          end
        end
`ifdef KEY_PARITY_EN
        CHECK: begin
          if (load_start) begin
            state_reg <= SHIFT;
            count_reg <= '0;
            err_reg   <= 1'b0;
          end else if (beat) begin
            state_reg <= IDLE;
            if (((^shadow_reg) ^ sdata) == 1'b0) begin
              key_reg       <= shadow_reg;
              key_valid_reg <= 1'b1;
              err_reg       <= 1'b0;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign key_out   = key_reg;
  assign key_valid = key_valid_reg;
  assign locked    = locked_reg;

endmodule
